// File: rtl/codec_pkg.sv
// Shared constants and types for the zigzag run-length encoder:
// block size, JPEG zigzag scan table, symbol record and FSM states.
package codec_pkg;

  localparam int BLK_N       = 64;
  localparam int COEFF_W_DEF = 16;
  localparam int RUN_W_DEF   = 4;

  // Raster index of each zigzag position.
  localparam logic [5:0] ZZ_ORDER [BLK_N] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  typedef struct packed {
    logic [RUN_W_DEF-1:0]          run;
    logic signed [COEFF_W_DEF-1:0] level;
    logic                          dc;
    logic                          eob;
  } rle_sym_t;

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_SCAN = 2'd1,
    ST_EOB  = 2'd2
  } enc_state_t;

endpackage

// File: rtl/coeff_block_buf.sv
// One 8x8 block of coefficients: synchronous write while filling,
// asynchronous read while scanning.
module coeff_block_buf #(
  parameter int COEFF_W = 16,
  parameter int DEPTH   = 64
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr,
  input  logic signed [COEFF_W-1:0]  wr_data,
  input  logic [$clog2(DEPTH)-1:0]   rd_addr,
  output logic signed [COEFF_W-1:0]  rd_data
);

  logic signed [COEFF_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/zigzag_rle_encoder.sv
// Buffers one raster-order 8x8 block, rescans it in zigzag order and
// emits DC / AC / ZRL / EOB run-length symbols through a registered output.
//
// state   | meaning
// FILL    | accepting 64 raster coefficients into the block buffer
// SCAN    | walking zigzag positions 0..63, emitting DC/AC/ZRL symbols
// EOB     | loading the end-of-block symbol and waiting for its acceptance
module zigzag_rle_encoder
  import codec_pkg::*;
#(
  parameter int COEFF_W = 16,
  parameter int RUN_W   = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic signed [COEFF_W-1:0] coeff_in,
  input  logic                      coeff_in_valid,
  output logic                      coeff_in_ready,
  output logic [RUN_W-1:0]          sym_run,
  output logic signed [COEFF_W-1:0] sym_level,
  output logic                      sym_dc,
  output logic                      sym_eob,
  output logic                      sym_valid,
  input  logic                      sym_ready
);

  localparam int ZRL_LEN = 1 << RUN_W;

  enc_state_t state_q, state_d;
  logic [5:0] wr_cnt_q, wr_cnt_d;
  logic [5:0] zz_q, zz_d;
  logic [5:0] zero_run_q, zero_run_d;

  logic                      buf_we;
  logic [5:0]                rd_addr;
  logic signed [COEFF_W-1:0] c;
  logic                      out_free;

  logic                      load;
  logic [RUN_W-1:0]          ld_run;
  logic signed [COEFF_W-1:0] ld_level;
  logic                      ld_dc;
  logic                      ld_eob;

  assign out_free = !sym_valid || sym_ready;
  assign rd_addr  = ZZ_ORDER[zz_q];
  assign buf_we   = (state_q == ST_FILL) && coeff_in_valid;

  coeff_block_buf #(
    .COEFF_W (COEFF_W),
    .DEPTH   (BLK_N)
  ) u_buf (
    .clk     (clk),
    .we      (buf_we),
    .wr_addr (wr_cnt_q),
    .wr_data (coeff_in),
    .rd_addr (rd_addr),
    .rd_data (c)
  );

  always_comb begin
    state_d        = state_q;
    wr_cnt_d       = wr_cnt_q;
    zz_d           = zz_q;
    zero_run_d     = zero_run_q;
    coeff_in_ready = 1'b0;
    load           = 1'b0;
    ld_run         = '0;
    ld_level       = '0;
    ld_dc          = 1'b0;
    ld_eob         = 1'b0;

    unique case (state_q)
      ST_FILL: begin
        coeff_in_ready = 1'b1;
        if (coeff_in_valid) begin
          wr_cnt_d = wr_cnt_q + 6'd1;
          if (wr_cnt_q == 6'd63) begin
            state_d    = ST_SCAN;
            wr_cnt_d   = '0;
            zz_d       = '0;
            zero_run_d = '0;
          end
        end
      end

      ST_SCAN: begin
        if (out_free) begin
          if (zz_q == 6'd0) begin
            load     = 1'b1;
            ld_dc    = 1'b1;
            ld_level = c;
            zz_d     = zz_q + 6'd1;
          end else if (c == '0) begin
            zero_run_d = zero_run_q + 6'd1;
            zz_d       = zz_q + 6'd1;
          end else if (zero_run_q >= 6'(ZRL_LEN)) begin
            // Position is not consumed; the same coefficient is revisited next cycle.
            load       = 1'b1;
            ld_run     = '1;
            zero_run_d = zero_run_q - 6'(ZRL_LEN);
          end else begin
            load       = 1'b1;
            ld_run     = zero_run_q[RUN_W-1:0];
            ld_level   = c;
            zero_run_d = '0;
            zz_d       = zz_q + 6'd1;
          end
          if ((zz_q == 6'd63) && (zz_d != zz_q)) begin
            state_d = ST_EOB;
            zz_d    = '0;
          end
        end
      end

      ST_EOB: begin
        if (sym_valid && sym_eob) begin
          if (sym_ready) begin
            state_d = ST_FILL;
          end
        end else if (out_free) begin
          load   = 1'b1;
          ld_eob = 1'b1;
        end
      end

      default: begin
        state_d = ST_FILL;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_FILL;
      wr_cnt_q   <= '0;
      zz_q       <= '0;
      zero_run_q <= '0;
      sym_valid  <= 1'b0;
      sym_run    <= '0;
      sym_level  <= '0;
      sym_dc     <= 1'b0;
      sym_eob    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_cnt_q   <= wr_cnt_d;
      zz_q       <= zz_d;
      zero_run_q <= zero_run_d;
      if (load) begin
        sym_valid <= 1'b1;
        sym_run   <= ld_run;
        sym_level <= ld_level;
        sym_dc    <= ld_dc;
        sym_eob   <= ld_eob;
      end else if (sym_ready) begin
        sym_valid <= 1'b0;
      end
    end
  end

endmodule
